// File: rtl/hazard_ctrl_pipe.sv
// hazard_ctrl_pipe
// Front-end pipeline registers acting on the hazard unit's commands. This
// block holds the PC register, the IF/ID register and the ID/EX register,
// and contains the Execute-stage forwarding muxes.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   StallF, StallD             hold PC / IF/ID register
//   FlushD, FlushE             bubble IF/ID / ID/EX register
//   PCSrcE, PCTargetE          taken redirect from Execute (beats StallF)
//   ForwardAE, ForwardBE       00 RF, 01 ResultW, 10 ALUResultM, 11 RF
//   InstrF                     instruction at PCF
//   RD1D, RD2D, ImmExtD, CtrlD Decode operands and control bundle
//   ALUResultM, ResultW        forwarding sources
//   PCF                        fetch address
//   InstrD, PCD, PCPlus4D      IF/ID contents; Rs1D/Rs2D decoded from InstrD
//   PCE, PCPlus4E, ImmExtE,
//   Rs1E, Rs2E, RdE, CtrlE     ID/EX contents
//   SrcAE, WriteDataE          forwarded Execute operands (combinational)
//   stall_cnt, flush_cnt       saturating performance event counters
module hazard_ctrl_pipe #(
  parameter int                XLEN      = 32,
  parameter logic [XLEN-1:0]   RESET_PC  = '0,
  parameter int                CTRL_W    = 12,
  parameter logic [31:0]       NOP_INSTR = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              StallF,
  input  logic              StallD,
  input  logic              FlushD,
  input  logic              FlushE,
  input  logic              PCSrcE,
  input  logic [XLEN-1:0]   PCTargetE,
  input  logic [1:0]        ForwardAE,
  input  logic [1:0]        ForwardBE,
  input  logic [31:0]       InstrF,
  input  logic [XLEN-1:0]   RD1D,
  input  logic [XLEN-1:0]   RD2D,
  input  logic [XLEN-1:0]   ImmExtD,
  input  logic [CTRL_W-1:0] CtrlD,
  input  logic [XLEN-1:0]   ALUResultM,
  input  logic [XLEN-1:0]   ResultW,
  output logic [XLEN-1:0]   PCF,
  output logic [31:0]       InstrD,
  output logic [XLEN-1:0]   PCD,
  output logic [XLEN-1:0]   PCPlus4D,
  output logic [4:0]        Rs1D,
  output logic [4:0]        Rs2D,
  output logic [XLEN-1:0]   PCE,
  output logic [XLEN-1:0]   PCPlus4E,
  output logic [XLEN-1:0]   ImmExtE,
  output logic [4:0]        Rs1E,
  output logic [4:0]        Rs2E,
  output logic [4:0]        RdE,
  output logic [CTRL_W-1:0] CtrlE,
  output logic [XLEN-1:0]   SrcAE,
  output logic [XLEN-1:0]   WriteDataE,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       flush_cnt
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  logic [XLEN-1:0]   pc_p0;
  logic [XLEN-1:0]   pc_plus4_p0;
  logic [31:0]       instr_p1;
  logic [XLEN-1:0]   pc_p1, pc_plus4_p1;
  logic [XLEN-1:0]   rd1_p2, rd2_p2, imm_p2, pc_p2, pc_plus4_p2;
  logic [4:0]        rs1_p2, rs2_p2, rd_p2;
  logic [CTRL_W-1:0] ctrl_p2;
  logic [15:0]       stall_cnt_q, flush_cnt_q;

  function automatic logic [15:0] sat_inc(input logic [15:0] cnt, input logic evt);
    if (evt && (cnt != 16'hFFFF)) return cnt + 16'd1;
    return cnt;
  endfunction

  // Code 11 is reserved and falls back to the register-file operand.
  function automatic logic [XLEN-1:0] fwd_sel(input logic [1:0] sel,
                                              input logic [XLEN-1:0] rf,
                                              input logic [XLEN-1:0] res_w,
                                              input logic [XLEN-1:0] alu_m);
    case (sel)
      2'b01:   return res_w;
      2'b10:   return alu_m;
      default: return rf;
    endcase
  endfunction

  assign pc_plus4_p0 = pc_p0 + PC_STEP;

  // Fetch stage: a taken redirect wins over a load-use stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_p0 <= RESET_PC;
    end else if (PCSrcE) begin
      pc_p0 <= PCTargetE;
    end else if (!StallF) begin
      pc_p0 <= pc_plus4_p0;
    end
  end

  // IF/ID boundary: flush > stall > load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_p1    <= NOP_INSTR;
      pc_p1       <= '0;
      pc_plus4_p1 <= '0;
    end else if (FlushD) begin
      instr_p1    <= NOP_INSTR;
      pc_p1       <= '0;
      pc_plus4_p1 <= '0;
    end else if (!StallD) begin
      instr_p1    <= InstrF;
      pc_p1       <= pc_p0;
      pc_plus4_p1 <= pc_plus4_p0;
    end
  end

  // ID/EX boundary: no hold path, a Decode stall is always paired with FlushE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd1_p2      <= '0;
      rd2_p2      <= '0;
      imm_p2      <= '0;
      pc_p2       <= '0;
      pc_plus4_p2 <= '0;
      rs1_p2      <= '0;
      rs2_p2      <= '0;
      rd_p2       <= '0;
      ctrl_p2     <= '0;
    end else if (FlushE) begin
      rd1_p2      <= '0;
      rd2_p2      <= '0;
      imm_p2      <= '0;
      pc_p2       <= '0;
      pc_plus4_p2 <= '0;
      rs1_p2      <= '0;
      rs2_p2      <= '0;
      rd_p2       <= '0;
      ctrl_p2     <= '0;
    end else begin
      rd1_p2      <= RD1D;
      rd2_p2      <= RD2D;
      imm_p2      <= ImmExtD;
      pc_p2       <= pc_p1;
      pc_plus4_p2 <= pc_plus4_p1;
      rs1_p2      <= instr_p1[19:15];
      rs2_p2      <= instr_p1[24:20];
      rd_p2       <= instr_p1[11:7];
      ctrl_p2     <= CtrlD;
    end
  end

  // A stall that coincides with a flush is counted only as a flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= sat_inc(stall_cnt_q, StallD && !FlushD);
      flush_cnt_q <= sat_inc(flush_cnt_q, FlushD);
    end
  end

  assign PCF        = pc_p0;
  assign InstrD     = instr_p1;
  assign PCD        = pc_p1;
  assign PCPlus4D   = pc_plus4_p1;
  assign Rs1D       = instr_p1[19:15];
  assign Rs2D       = instr_p1[24:20];
  assign PCE        = pc_p2;
  assign PCPlus4E   = pc_plus4_p2;
  assign ImmExtE    = imm_p2;
  assign Rs1E       = rs1_p2;
  assign Rs2E       = rs2_p2;
  assign RdE        = rd_p2;
  assign CtrlE      = ctrl_p2;
  assign SrcAE      = fwd_sel(ForwardAE, rd1_p2, ResultW, ALUResultM);
  assign WriteDataE = fwd_sel(ForwardBE, rd2_p2, ResultW, ALUResultM);
  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_pipe.sv
// Testbench for hazard_ctrl_pipe: directed scenarios plus randomized hazard
// traffic checked against a cycle-level reference model of the pipeline
// registers. A second instance with RESET_PC near the top of the address
// space covers PC wrap-around.
module tb_hazard_ctrl_pipe;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        StallF, StallD, FlushD, FlushE, PCSrcE;
  logic [31:0] PCTargetE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] InstrF, RD1D, RD2D, ImmExtD, ALUResultM, ResultW;
  logic [11:0] CtrlD;

  logic [31:0] PCF, InstrD, PCD, PCPlus4D, PCE, PCPlus4E, ImmExtE, SrcAE, WriteDataE;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE;
  logic [11:0] CtrlE;
  logic [15:0] stall_cnt, flush_cnt;

  logic [31:0] PCF_w, InstrD_w, PCD_w, PCPlus4D_w, PCE_w, PCPlus4E_w, ImmExtE_w;
  logic [31:0] SrcAE_w, WriteDataE_w;
  logic [4:0]  Rs1D_w, Rs2D_w, Rs1E_w, Rs2E_w, RdE_w;
  logic [11:0] CtrlE_w;
  logic [15:0] stall_cnt_w, flush_cnt_w;

  int errors = 0;
  int checks = 0;

  hazard_ctrl_pipe dut (
    .clk(clk), .rst_n(rst_n), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .FlushE(FlushE), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .ForwardAE(ForwardAE),
    .ForwardBE(ForwardBE), .InstrF(InstrF), .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD),
    .CtrlD(CtrlD), .ALUResultM(ALUResultM), .ResultW(ResultW), .PCF(PCF),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .Rs1D(Rs1D), .Rs2D(Rs2D),
    .PCE(PCE), .PCPlus4E(PCPlus4E), .ImmExtE(ImmExtE), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .CtrlE(CtrlE), .SrcAE(SrcAE), .WriteDataE(WriteDataE),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_ctrl_pipe #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .FlushE(FlushE), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .ForwardAE(ForwardAE),
    .ForwardBE(ForwardBE), .InstrF(InstrF), .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD),
    .CtrlD(CtrlD), .ALUResultM(ALUResultM), .ResultW(ResultW), .PCF(PCF_w),
    .InstrD(InstrD_w), .PCD(PCD_w), .PCPlus4D(PCPlus4D_w), .Rs1D(Rs1D_w), .Rs2D(Rs2D_w),
    .PCE(PCE_w), .PCPlus4E(PCPlus4E_w), .ImmExtE(ImmExtE_w), .Rs1E(Rs1E_w), .Rs2E(Rs2E_w),
    .RdE(RdE_w), .CtrlE(CtrlE_w), .SrcAE(SrcAE_w), .WriteDataE(WriteDataE_w),
    .stall_cnt(stall_cnt_w), .flush_cnt(flush_cnt_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural view of the front end as the reference model sees it.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instrD, pcD, pcp4D;
    logic [31:0] rd1E, rd2E, immE, pcE, pcp4E;
    logic [4:0]  rs1E, rs2E, rdE;
    logic [11:0] ctrlE;
    logic [15:0] sc, fc;
  } mstate_t;

  mstate_t m;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic mstate_t model_reset();
    mstate_t n;
    n = '0;
    n.pc = 32'h0;
    n.instrD = NOP;
    return n;
  endfunction

  function automatic mstate_t model_next(input mstate_t s);
    mstate_t n;
    n = s;
    if (PCSrcE)       n.pc = PCTargetE;
    else if (!StallF) n.pc = s.pc + 32'd4;
    if (FlushD) begin
      n.instrD = NOP; n.pcD = 0; n.pcp4D = 0;
    end else if (!StallD) begin
      n.instrD = InstrF; n.pcD = s.pc; n.pcp4D = s.pc + 32'd4;
    end
    if (FlushE) begin
      n.rd1E = 0; n.rd2E = 0; n.immE = 0; n.pcE = 0; n.pcp4E = 0;
      n.rs1E = 0; n.rs2E = 0; n.rdE = 0; n.ctrlE = 0;
    end else begin
      n.rd1E = RD1D; n.rd2E = RD2D; n.immE = ImmExtD; n.pcE = s.pcD; n.pcp4E = s.pcp4D;
      n.rs1E = s.instrD[19:15]; n.rs2E = s.instrD[24:20]; n.rdE = s.instrD[11:7];
      n.ctrlE = CtrlD;
    end
    if (StallD && !FlushD && s.sc != 16'hFFFF) n.sc = s.sc + 16'd1;
    if (FlushD && s.fc != 16'hFFFF) n.fc = s.fc + 16'd1;
    return n;
  endfunction

  function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] rf);
    if (sel == 2'b01) return ResultW;
    if (sel == 2'b10) return ALUResultM;
    return rf;
  endfunction

  task automatic check_all();
    check_eq("PCF", PCF, m.pc);
    check_eq("InstrD", InstrD, m.instrD);
    check_eq("PCD", PCD, m.pcD);
    check_eq("PCPlus4D", PCPlus4D, m.pcp4D);
    check_eq("Rs1D", 32'(Rs1D), 32'(m.instrD[19:15]));
    check_eq("Rs2D", 32'(Rs2D), 32'(m.instrD[24:20]));
    check_eq("PCE", PCE, m.pcE);
    check_eq("PCPlus4E", PCPlus4E, m.pcp4E);
    check_eq("ImmExtE", ImmExtE, m.immE);
    check_eq("Rs1E", 32'(Rs1E), 32'(m.rs1E));
    check_eq("Rs2E", 32'(Rs2E), 32'(m.rs2E));
    check_eq("RdE", 32'(RdE), 32'(m.rdE));
    check_eq("CtrlE", 32'(CtrlE), 32'(m.ctrlE));
    check_eq("SrcAE", SrcAE, fwd(ForwardAE, m.rd1E));
    check_eq("WriteDataE", WriteDataE, fwd(ForwardBE, m.rd2E));
    check_eq("stall_cnt", 32'(stall_cnt), 32'(m.sc));
    check_eq("flush_cnt", 32'(flush_cnt), 32'(m.fc));
  endtask

  // One clock with the currently driven inputs; outputs sampled 1ns after the edge.
  task automatic step();
    mstate_t nxt;
    nxt = model_next(m);
    @(posedge clk);
    #1;
    m = nxt;
    check_all();
  endtask

  task automatic hazards(input logic sf, input logic sd, input logic fd,
                         input logic fe, input logic ps, input logic [31:0] tgt);
    StallF = sf; StallD = sd; FlushD = fd; FlushE = fe; PCSrcE = ps; PCTargetE = tgt;
  endtask

  initial begin : main
    logic [31:0] exp_fwd [4];
    logic [15:0] sc_before;
    exp_fwd = '{32'd1, 32'd2, 32'd3, 32'd1};

    rst_n = 1'b0;
    hazards(0, 0, 0, 0, 0, 32'h0);
    ForwardAE = 2'b00; ForwardBE = 2'b00;
    InstrF = 32'h0050_0093;
    RD1D = 0; RD2D = 0; ImmExtD = 0; CtrlD = 12'h0; ALUResultM = 0; ResultW = 0;

    repeat (2) @(posedge clk);
    #1;
    m = model_reset();
    check_all();
    check_eq("reset_PCF", PCF, 32'h0);
    check_eq("reset_PCF_wrap", PCF_w, 32'hFFFF_FFFC);
    rst_n = 1'b1;

    // Free-running fetch after reset.
    CtrlD = 12'h5A5;
    step();
    check_eq("seq_PCF1", PCF, 32'h4);
    check_eq("seq_InstrD1", InstrD, 32'h0050_0093);
    check_eq("wrap_PCF", PCF_w, 32'h0);
    step();
    check_eq("seq_PCF2", PCF, 32'h8);
    check_eq("seq_RdE", 32'(RdE), 32'd1);

    // Load-use stall at PCF=8.
    hazards(1, 1, 0, 1, 0, 32'h0);
    step();
    check_eq("stall_PCF", PCF, 32'h8);
    check_eq("stall_InstrD", InstrD, 32'h0050_0093);
    check_eq("stall_CtrlE", 32'(CtrlE), 32'h0);
    check_eq("stall_cnt1", 32'(stall_cnt), 32'd1);
    hazards(0, 0, 0, 0, 0, 32'h0);
    step();

    // Taken branch.
    hazards(0, 0, 1, 1, 1, 32'h40);
    step();
    check_eq("br_PCF", PCF, 32'h40);
    check_eq("br_InstrD", InstrD, NOP);
    check_eq("br_CtrlE", 32'(CtrlE), 32'h0);
    check_eq("br_flush_cnt", 32'(flush_cnt), 32'd1);

    // Stall and redirect together.
    sc_before = stall_cnt;
    hazards(1, 1, 1, 1, 1, 32'h80);
    step();
    check_eq("both_PCF", PCF, 32'h80);
    check_eq("both_InstrD", InstrD, NOP);
    check_eq("both_stall_cnt", 32'(stall_cnt), 32'(sc_before));

    // Forwarding muxes.
    hazards(0, 0, 0, 0, 0, 32'h0);
    RD1D = 32'd1; RD2D = 32'd1;
    step();
    ResultW = 32'd2; ALUResultM = 32'd3;
    for (int i = 0; i < 4; i++) begin
      ForwardAE = 2'(i);
      #1;
      check_eq("fwdA", SrcAE, exp_fwd[i]);
    end
    for (int i = 0; i < 4; i++) begin
      ForwardBE = 2'(i);
      #1;
      check_eq("fwdB", WriteDataE, exp_fwd[i]);
    end

    // Randomized hazard traffic.
    for (int i = 0; i < 2000; i++) begin
      StallF     = ($urandom_range(0, 3) == 0);
      StallD     = ($urandom_range(0, 3) == 0);
      FlushD     = ($urandom_range(0, 7) == 0);
      FlushE     = ($urandom_range(0, 5) == 0);
      PCSrcE     = ($urandom_range(0, 9) == 0);
      PCTargetE  = $urandom & 32'hFFFF_FFFC;
      ForwardAE  = 2'($urandom);
      ForwardBE  = 2'($urandom);
      InstrF     = $urandom;
      RD1D       = $urandom;
      RD2D       = $urandom;
      ImmExtD    = $urandom;
      CtrlD      = 12'($urandom);
      ALUResultM = $urandom;
      ResultW    = $urandom;
      step();
    end

    // Asynchronous reset in the middle of a stall cycle.
    hazards(1, 1, 0, 1, 0, 32'h0);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    m = model_reset();
    check_all();
    check_eq("arst_PCF", PCF, 32'h0);
    check_eq("arst_InstrD", InstrD, NOP);
    check_eq("arst_stall_cnt", 32'(stall_cnt), 32'd0);
    #2;
    rst_n = 1'b1;

    // Flush counter saturation.
    hazards(0, 0, 1, 1, 0, 32'h0);
    for (int i = 0; i < 70000; i++) step();
    check_eq("flush_sat", 32'(flush_cnt), 32'h0000_FFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_pipe.md
Name: hazard_ctrl_pipe

Overview:
Front-end pipeline register block that acts on the hazard unit's stall, flush and forward commands. It holds the PC register, the IF/ID register and the ID/EX register, and contains the Execute-stage forwarding muxes. It consumes StallF/StallD/FlushD/FlushE/ForwardAE/ForwardBE and returns the Rs1E/Rs2E/RdE/Rs1D/Rs2D fields the hazard unit needs. It also keeps saturating stall and flush event counters for performance debug.

Parameters:
XLEN, 32, datapath width
RESET_PC, 32'h0000_0000, PCF value after reset
CTRL_W, 12, width of the opaque Decode control bundle carried into Execute
NOP_INSTR, 32'h0000_0013, instruction word inserted into IF/ID on reset or flush (addi x0,x0,0)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
StallF  in  1  hold PC register
StallD  in  1  hold IF/ID register
FlushD  in  1  clear IF/ID register to bubble
FlushE  in  1  clear ID/EX register to bubble
PCSrcE  in  1  taken branch/jump redirect from Execute
PCTargetE  in  XLEN  redirect target
ForwardAE  in  2  SrcAE select: 00 RF, 01 ResultW, 10 ALUResultM
ForwardBE  in  2  WriteDataE select, same encoding
InstrF  in  32  instruction memory read data for PCF
RD1D, RD2D, ImmExtD  in  XLEN each  register file and immediate outputs in Decode
CtrlD  in  CTRL_W  decoded control bundle
ALUResultM  in  XLEN  Memory-stage forward source
ResultW  in  XLEN  Writeback-stage forward source
PCF  out  XLEN  fetch address
InstrD, PCD, PCPlus4D  out  32/XLEN/XLEN  IF/ID register contents
Rs1D, Rs2D  out  5 each  InstrD[19:15], InstrD[24:20], combinational
PCE, PCPlus4E, ImmExtE  out  XLEN each  ID/EX register contents
Rs1E, Rs2E, RdE  out  5 each  ID/EX register fields
CtrlE  out  CTRL_W  ID/EX control bundle
SrcAE, WriteDataE  out  XLEN each  forwarded operands, combinational
stall_cnt, flush_cnt  out  16 each  saturating event counters

Behaviour:
- Reset (rst_n=0, asynchronous): PCF=RESET_PC; InstrD=NOP_INSTR; PCD, PCPlus4D = 0; all ID/EX fields = 0, including CtrlE=0 (bubble); both counters = 0. Reset takes effect immediately, including mid-stall and mid-flush. No pending state survives reset.
- PC register: when PCSrcE=1, PCF<=PCTargetE, even if StallF=1; a taken redirect always wins over a load stall. Otherwise, when StallF=1, PCF holds. Otherwise PCF<=PCF+4, with wrap modulo 2^XLEN.
- IF/ID register, priority FlushD > StallD > load:
  - FlushD: InstrD<=NOP_INSTR, PCD<=0, PCPlus4D<=0.
  - StallD: all fields hold.
  - Load: InstrD<=InstrF, PCD<=PCF, PCPlus4D<=PCF+4.
- ID/EX register:
  - FlushE: every field <=0 (CtrlE=0 means no RegWrite, no MemWrite, no branch).
  - Otherwise load RD1D, RD2D, ImmExtD, PCD, PCPlus4D, CtrlD, plus Rs1D, Rs2D and RdD=InstrD[11:7].
  - The ID/EX register has no stall input; a Decode stall always pairs with FlushE.
- Forwarding muxes (combinational, zero latency): SrcAE selects by ForwardAE from {RD1E, ResultW, ALUResultM}; WriteDataE likewise selects by ForwardBE from RD2E. Code 11 is reserved and selects the RF value (00 behaviour).
- Latency: an instruction fetched at PCF in cycle n appears on InstrD in n+1 and on the E outputs in n+2, absent stall or flush.
- Counters: stall_cnt increments in each cycle where StallD=1 and FlushD=0. flush_cnt increments in each cycle where FlushD=1. Both saturate at 16'hFFFF and never wrap.
- No combinational path from any hazard input to PCF, InstrD or the E fields.

Test Plan:
- Reset: rst_n low for 2 cycles, then high, no hazards, InstrF=32'h00500093 -> PCF sequence 0,4,8; InstrD=NOP_INSTR in cycle 1 and 32'h00500093 in cycle 2; RdE=1 in cycle 3.
- Load-use stall: assert StallF=StallD=FlushE for one cycle at PCF=8 -> PCF stays 8 for one extra cycle, InstrD holds, CtrlE=0 next cycle, stall_cnt=1.
- Taken branch: PCSrcE=FlushD=FlushE=1 with PCTargetE=32'h40 -> next cycle PCF=32'h40, InstrD=NOP_INSTR, CtrlE=0, flush_cnt=1.
- Simultaneous stall and redirect: StallF=StallD=FlushD=FlushE=PCSrcE=1, PCTargetE=32'h80 -> PCF=32'h80, InstrD=NOP_INSTR, stall_cnt unchanged.
- Forwarding: RD1E=1, ResultW=2, ALUResultM=3; drive ForwardAE=00/01/10/11 -> SrcAE=1/2/3/1; repeat on ForwardBE -> WriteDataE.
- Saturation and wrap: force 70000 consecutive flush cycles -> flush_cnt holds 16'hFFFF; with RESET_PC=32'hFFFF_FFFC, one free-running cycle -> PCF=0. Asynchronous reset mid-stall -> all outputs return to reset values immediately.
